// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the uCISC control unit and the iterative
// multiply/divide sequencer.
//   master: control unit side (drives request, operands and current flags)
//   slave : sequencer side (drives busy/done strobes, results and flags word)
// Signals:
//   start, op_code, source, destination, flags          -> request
//   busy, done, result_out, remainder_out, flags_out,
//   write_flags                                          <- completion
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] source;
    logic [WIDTH-1:0] destination;
    logic [15:0]      flags;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_out;
    logic [WIDTH-1:0] remainder_out;
    logic [15:0]      flags_out;
    logic             write_flags;

    modport master (
        output start, op_code, source, destination, flags,
        input  busy, done, result_out, remainder_out, flags_out, write_flags
    );

    modport slave (
        input  start, op_code, source, destination, flags,
        output busy, done, result_out, remainder_out, flags_out, write_flags
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply (op 4'hC) / restoring divide (op 4'hD) for the
// uCISC core, one bit per clock.
// Ports:
//   clock   : rising-edge system clock
//   reset_n : asynchronous active-low reset
//   bus     : muldiv_sequencer_if.slave (request in, results/flags out)
// flags_out layout: {flags[15:5] sampled at start, divide_error, overflow,
//                    carry, negative, zero}; write_flags mirrors done.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEPS = 16
) (
    input logic             clock,
    input logic             reset_n,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor
    logic [WIDTH-1:0] hi;        // product high half / partial remainder
    logic [WIDTH-1:0] lo;        // multiplier shifting out / quotient shifting in
    logic [10:0]      flags_hi;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rem_q;
    logic [15:0]      flags_q;

    logic             start_ok;
    logic             start_div;
    logic             div_zero;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic             mul_ovf;

    // Requests are taken in IDLE and in DONE, the latter giving back-to-back ops.
    assign start_div = (bus.op_code == 4'hD);
    assign start_ok  = bus.start && (bus.op_code == 4'hC || start_div) && (state != RUN);
    assign div_zero  = start_div && (bus.source == '0);

    always_comb begin
        hi_nxt  = hi;
        lo_nxt  = lo;
        sum     = '0;
        trial   = '0;
        if (is_div) begin
            // Restoring step: shift next dividend bit into the remainder,
            // keep the subtraction only when it does not borrow.
            trial = {hi, lo[WIDTH-1]} - {1'b0, opnd};
            if (!trial[WIDTH]) begin
                hi_nxt = trial[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = {hi[WIDTH-2:0], lo[WIDTH-1]};
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add: the carry of the add becomes the new top bit as the
            // whole {carry, hi, lo} accumulator shifts right by one.
            sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
        mul_ovf = !is_div && (hi_nxt != '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_nxt = div_zero ? DONE : RUN;
                else          state_nxt = IDLE;
            end
            RUN:     if (cnt == LAST) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            flags_hi <= '0;
            result_q <= '0;
            rem_q    <= '0;
            flags_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN) begin
                hi  <= hi_nxt;
                lo  <= lo_nxt;
                cnt <= cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    result_q <= lo_nxt;
                    rem_q    <= hi_nxt;
                    flags_q  <= {flags_hi, 1'b0, mul_ovf, mul_ovf,
                                 lo_nxt[WIDTH-1], (lo_nxt == '0)};
                end
            end else if (start_ok) begin
                is_div   <= start_div;
                flags_hi <= bus.flags[15:5];
                cnt      <= '0;
                hi       <= '0;
                if (start_div) begin
                    opnd <= bus.source;
                    lo   <= bus.destination;
                end else begin
                    opnd <= bus.destination;
                    lo   <= bus.source;
                end
                if (div_zero) begin
                    result_q <= '1;
                    rem_q    <= bus.destination;
                    flags_q  <= {bus.flags[15:5], 5'b10010};
                end
            end
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.write_flags   = (state == DONE);
    assign bus.result_out    = result_q;
    assign bus.remainder_out = rem_q;
    assign bus.flags_out     = flags_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    logic clock;
    logic reset_n;

    muldiv_sequencer_if #(.WIDTH(16)) bus ();

    muldiv_sequencer #(.WIDTH(16), .STEPS(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] res;
        logic [15:0] rem;
        logic [15:0] flg;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: plain arithmetic operators, independent of the iteration.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] dst,
                                   input logic [15:0] src, input logic [15:0] flg);
        exp_t        e;
        logic [31:0] p;
        logic        cy;
        logic        de;
        cy = 1'b0;
        de = 1'b0;
        if (op == 4'hC) begin
            p     = {16'h0, dst} * {16'h0, src};
            e.res = p[15:0];
            e.rem = p[31:16];
            cy    = (p[31:16] != 16'h0);
            e.lat = 17;
        end else if (src == 16'h0) begin
            e.res = 16'hFFFF;
            e.rem = dst;
            de    = 1'b1;
            e.lat = 1;
        end else begin
            e.res = dst / src;
            e.rem = dst % src;
            e.lat = 17;
        end
        e.flg = {flg[15:5], de, cy, cy, e.res[15], (e.res == 16'h0)};
        return e;
    endfunction

    // Drives a request now (caller is mid-cycle) and records its expectation.
    task automatic issue(input logic [3:0] op, input logic [15:0] dst,
                         input logic [15:0] src, input logic [15:0] flg);
        bus.start       = 1'b1;
        bus.op_code     = op;
        bus.destination = dst;
        bus.source      = src;
        bus.flags       = flg;
        sb.push_back(model(op, dst, src, flg));
    endtask

    // Counts edges from the start edge (edge 1) until done, then checks the
    // oldest expectation. poke > 0 pulses a multiply request after that edge.
    task automatic wait_done(input string tag, input int poke);
        int   edges;
        exp_t e;
        edges = 0;
        do begin
            @(posedge clock);
            #1;
            edges++;
            if (edges == 1) bus.start = 1'b0;
            if (poke > 0 && edges == poke) begin
                bus.start       = 1'b1;
                bus.op_code     = 4'hC;
                bus.destination = 16'h0102;
                bus.source      = 16'h0304;
            end
            if (poke > 0 && edges == poke + 1) bus.start = 1'b0;
        end while (bus.done !== 1'b1 && edges < 40);
        chk({tag, "_done"}, {31'h0, bus.done}, 32'h1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'h0, 32'h1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, edges, e.lat);
            chk({tag, "_result"}, {16'h0, bus.result_out}, {16'h0, e.res});
            chk({tag, "_remainder"}, {16'h0, bus.remainder_out}, {16'h0, e.rem});
            chk({tag, "_flags"}, {16'h0, bus.flags_out}, {16'h0, e.flg});
            chk({tag, "_write_flags"}, {31'h0, bus.write_flags}, 32'h1);
            chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h1);
        end
    endtask

    initial begin
        logic saw;
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.op_code     = 4'h0;
        bus.source      = 16'h0;
        bus.destination = 16'h0;
        bus.flags       = 16'h0;

        #3;
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_result", {16'h0, bus.result_out}, 32'h0);
        chk("rst_remainder", {16'h0, bus.remainder_out}, 32'h0);
        chk("rst_flags", {16'h0, bus.flags_out}, 32'h0);
        chk("rst_write_flags", {31'h0, bus.write_flags}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        @(negedge clock);
        issue(4'hC, 16'h0005, 16'h0003, 16'h0000);
        wait_done("mul_5x3", 0);

        @(negedge clock);
        issue(4'hC, 16'h1000, 16'h0020, 16'h0000);
        wait_done("mul_ovf", 0);
        @(posedge clock);
        #1;
        chk("strobe_done_low", {31'h0, bus.done}, 32'h0);
        chk("strobe_busy_low", {31'h0, bus.busy}, 32'h0);
        chk("hold_result", {16'h0, bus.result_out}, 32'h0);
        chk("hold_remainder", {16'h0, bus.remainder_out}, 32'h2);

        @(negedge clock);
        issue(4'hD, 16'h0064, 16'h0007, 16'hA500);
        bus.flags = 16'hA500;
        wait_done("div_100_7", 0);
        bus.flags = 16'h0000;

        @(negedge clock);
        issue(4'hD, 16'h1234, 16'h0000, 16'h0000);
        wait_done("div_zero", 0);

        @(negedge clock);
        issue(4'hC, 16'hFFFF, 16'hFFFF, 16'h3FE0);
        wait_done("mul_max", 0);

        @(negedge clock);
        issue(4'hD, 16'hFFFF, 16'h0001, 16'h0000);
        wait_done("div_by_one", 0);

        // Request during RUN (counter 5) must be dropped.
        @(negedge clock);
        issue(4'hC, 16'h0011, 16'h0022, 16'h0000);
        wait_done("run_ignore", 6);
        // Held start during DONE starts the next op with no idle cycle.
        issue(4'hC, 16'h00FF, 16'h0101, 16'h0000);
        wait_done("back_to_back", 0);
        bus.start = 1'b0;

        // Asynchronous reset at RUN counter 8.
        @(negedge clock);
        issue(4'hC, 16'h1234, 16'h5678, 16'h0000);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        chk("abort_done", {31'h0, bus.done}, 32'h0);
        chk("abort_result", {16'h0, bus.result_out}, 32'h0);
        chk("abort_remainder", {16'h0, bus.remainder_out}, 32'h0);
        chk("abort_flags", {16'h0, bus.flags_out}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (25) begin
            @(posedge clock);
            #1;
            saw = saw | bus.done;
        end
        chk("no_done_after_abort", {31'h0, saw}, 32'h0);

        @(negedge clock);
        bus.start   = 1'b1;
        bus.op_code = 4'hA;
        saw = 1'b0;
        repeat (4) begin
            @(posedge clock);
            #1;
            saw = saw | bus.busy | bus.done;
        end
        bus.start = 1'b0;
        chk("bad_op_ignored", {31'h0, saw}, 32'h0);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
